// File: rtl/uart_tx_serializer_pkg.sv
// Shared definitions for the UART transmit path: FSM encodings, logical line levels
// and default frame geometry.
package uart_tx_serializer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } tx_state_e;

    localparam logic LOGIC_IDLE  = 1'b1;
    localparam logic LOGIC_START = 1'b0;
    localparam logic LOGIC_STOP  = 1'b1;

    localparam int DEF_OVERSAMPLE = 16;
    localparam int DEF_DATA_BITS  = 8;

    function automatic logic line_level(input logic lvl, input logic invert);
        return lvl ^ invert;
    endfunction

endpackage

// File: rtl/uart_tx_serializer_if.sv
// Read side of the tx FIFO (first-word-fall-through) as seen by the serializer.
interface uart_tx_serializer_if
    import uart_tx_serializer_pkg::*;
#(
    parameter int DATA_BITS = DEF_DATA_BITS
);
    logic [DATA_BITS-1:0] fifo_data;
    logic                 fifo_empty;
    logic                 fifo_pop;

    modport master (
        input  fifo_data,
        input  fifo_empty,
        output fifo_pop
    );

    modport slave (
        output fifo_data,
        output fifo_empty,
        input  fifo_pop
    );
endinterface

// File: rtl/uart_tx_serializer_bit_timer.sv
// Oversample tick counter: counts 0..OVERSAMPLE-1 and flags the last tick of a bit period.
module uart_tx_serializer_bit_timer
    import uart_tx_serializer_pkg::*;
#(
    parameter int OVERSAMPLE = DEF_OVERSAMPLE
) (
    input  logic line_clock,
    input  logic reset,
    input  logic clear,
    output logic bit_end
);
    localparam int TW = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;

    logic [TW-1:0] tick_q;
    logic [TW-1:0] tick_d;

    // Power-of-two OVERSAMPLE lets the counter wrap on its own at bit_end.
    always_comb begin
        tick_d = clear ? '0 : tick_q + TW'(1);
    end

    always_ff @(posedge line_clock) begin
        if (reset) begin
            tick_q <= '0;
        end else begin
            tick_q <= tick_d;
        end
    end

    assign bit_end = (tick_q == TW'(OVERSAMPLE - 1));

endmodule

// File: rtl/uart_tx_serializer.sv
// UART transmit serializer: pops bytes from the tx FIFO and shifts them out as
// start / data (LSB first) / stop frames at OVERSAMPLE line_clock cycles per bit.
//
// state | meaning
// IDLE  | line at idle level, waiting for enable and a non-empty FIFO
// START | start bit on the line
// DATA  | data bits on the line, shreg[0] is the current bit
// STOP  | stop bit(s) on the line; may reload directly into START
module uart_tx_serializer
    import uart_tx_serializer_pkg::*;
#(
    parameter int DATA_BITS  = DEF_DATA_BITS,
    parameter int OVERSAMPLE = DEF_OVERSAMPLE,
    parameter int STOP_BITS  = 1,
    parameter int INVERT     = 1
) (
    input  logic                   line_clock,
    input  logic                   reset,
    input  logic                   enable,
    uart_tx_serializer_if.master   fifo_if,
    output logic                   tx_pin,
    output logic                   busy
);
    localparam int   BW  = $clog2(DATA_BITS + 1);
    localparam logic INV = (INVERT != 0);
    localparam logic [BW-1:0] LAST_DATA = BW'(DATA_BITS - 1);
    localparam logic [BW-1:0] LAST_STOP = BW'(STOP_BITS - 1);

    tx_state_e            state_q, state_d;
    logic [BW-1:0]        bit_idx_q, bit_idx_d;
    logic [DATA_BITS-1:0] shreg_q, shreg_d;
    logic                 tx_q, tx_d;
    logic                 busy_q, busy_d;

    logic bit_end;
    logic last_stop;
    logic load;
    logic timer_clear;
    logic line_lvl;

    assign last_stop   = (state_q == ST_STOP) && (bit_idx_q == LAST_STOP) && bit_end;
    assign load        = enable && !fifo_if.fifo_empty && !reset &&
                         ((state_q == ST_IDLE) || last_stop);
    assign timer_clear = (state_q == ST_IDLE) || load;

    assign fifo_if.fifo_pop = load;

    uart_tx_serializer_bit_timer #(
        .OVERSAMPLE (OVERSAMPLE)
    ) u_bit_timer (
        .line_clock (line_clock),
        .reset      (reset),
        .clear      (timer_clear),
        .bit_end    (bit_end)
    );

    always_comb begin
        state_d   = state_q;
        bit_idx_d = bit_idx_q;
        shreg_d   = shreg_q;

        case (state_q)
            ST_IDLE: ;
            ST_START: begin
                if (bit_end) begin
                    state_d   = ST_DATA;
                    bit_idx_d = '0;
                end
            end
            ST_DATA: begin
                if (bit_end) begin
                    shreg_d = shreg_q >> 1;
                    if (bit_idx_q == LAST_DATA) begin
                        state_d   = ST_STOP;
                        bit_idx_d = '0;
                    end else begin
                        bit_idx_d = bit_idx_q + BW'(1);
                    end
                end
            end
            ST_STOP: begin
                // bit_idx is reused to count stop bits
                if (bit_end) begin
                    if (bit_idx_q == LAST_STOP) begin
                        state_d = ST_IDLE;
                    end else begin
                        bit_idx_d = bit_idx_q + BW'(1);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (load) begin
            shreg_d   = fifo_if.fifo_data;
            state_d   = ST_START;
            bit_idx_d = '0;
        end

        busy_d = (state_d != ST_IDLE);

        // tx_pin is registered, so it shows the level belonging to the next state.
        case (state_d)
            ST_START: line_lvl = LOGIC_START;
            ST_DATA:  line_lvl = shreg_d[0];
            ST_STOP:  line_lvl = LOGIC_STOP;
            default:  line_lvl = LOGIC_IDLE;
        endcase
        tx_d = line_level(line_lvl, INV);
    end

    always_ff @(posedge line_clock) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            bit_idx_q <= '0;
            shreg_q   <= '0;
            tx_q      <= line_level(LOGIC_IDLE, INV);
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_idx_q <= bit_idx_d;
            shreg_q   <= shreg_d;
            tx_q      <= tx_d;
            busy_q    <= busy_d;
        end
    end

    assign tx_pin = tx_q;
    assign busy   = busy_q;

endmodule
